seq_arith_unit: RTL and testbench

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

---
 rtl/seq_arith_unit.sv | 215 +++++++++++++++++++++
 tb/tb_seq_arith_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// Sequential signed arithmetic unit: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV on operand magnitudes, with a valid/ready handshake on both sides.
module seq_arith_unit #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     a,
   input  logic [DATA_WIDTH-1:0]     b,
   input  logic [1:0]                alu_fun,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*DATA_WIDTH-1:0]   arith_out,
   output logic                      carry_out,
   output logic                      overflow,
   output logic                      div_by_zero
);
   // state | meaning
   // IDLE  | ready for a new operation
   // CALC  | MUL/DIV iterating, one bit per cycle for DATA_WIDTH cycles
   // DONE  | result presented, waiting for out_ready

   localparam int W          = DATA_WIDTH;
   localparam int OUT_WIDTH  = 2 * DATA_WIDTH;
   localparam int CW         = $clog2(DATA_WIDTH);

   localparam logic [1:0] FUN_ADD = 2'b00;
   localparam logic [1:0] FUN_SUB = 2'b01;
   localparam logic [1:0] FUN_DIV = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [CW-1:0]          r_cnt;
   logic                   r_is_div;
   logic                   r_neg_res;
   logic                   r_neg_rem;
   logic                   r_div_ovf;
   logic [OUT_WIDTH-1:0]   r_acc;
   logic [OUT_WIDTH-1:0]   r_mcand;
   logic [W-1:0]           r_q;
   logic [W-1:0]           r_rem;
   logic [W-1:0]           r_dvsr;

   logic [OUT_WIDTH-1:0]   r_out;
   logic                   r_carry;
   logic                   r_ovf;
   logic                   r_dbz;

   logic                   w_accept;
   logic                   w_fast;
   logic                   w_last;
   logic [W-1:0]           w_a_mag;
   logic [W-1:0]           w_b_mag;
   logic [W:0]             w_sum;
   logic [W:0]             w_dif;
   logic [OUT_WIDTH-1:0]   w_fast_out;
   logic                   w_fast_c;
   logic                   w_fast_v;
   logic                   w_fast_z;

   logic [OUT_WIDTH-1:0]   w_acc_nxt;
   logic [OUT_WIDTH-1:0]   w_prod;
   logic                   w_mul_ovf;
   logic [W:0]             w_shift;
   logic [W:0]             w_diff;
   logic                   w_ge;
   logic [W-1:0]           w_rem_nxt;
   logic [W-1:0]           w_quo_nxt;
   logic [W-1:0]           w_quo_fix;
   logic [W-1:0]           w_rem_fix;

   assign w_accept = in_valid && (r_state == S_IDLE);
   assign w_fast   = ~alu_fun[1] || ((alu_fun == FUN_DIV) && (b == '0));
   assign w_last   = (r_state == S_CALC) && (r_cnt == '0);

   assign w_a_mag  = a[W-1] ? -a : a;
   assign w_b_mag  = b[W-1] ? -b : b;
   assign w_sum    = {a[W-1], a} + {b[W-1], b};
   assign w_dif    = {a[W-1], a} - {b[W-1], b};

   // Unsigned carry/borrow recovered from the sign-extended result's top bit.
   always_comb begin
      w_fast_out = '0;
      w_fast_c   = 1'b0;
      w_fast_v   = 1'b0;
      w_fast_z   = 1'b0;
      case (alu_fun)
         FUN_ADD: begin
            w_fast_out = {{(OUT_WIDTH-W-1){w_sum[W]}}, w_sum};
            w_fast_c   = w_sum[W] ^ a[W-1] ^ b[W-1];
            w_fast_v   = w_sum[W] ^ w_sum[W-1];
         end
         FUN_SUB: begin
            w_fast_out = {{(OUT_WIDTH-W-1){w_dif[W]}}, w_dif};
            w_fast_c   = w_dif[W] ^ a[W-1] ^ b[W-1];
            w_fast_v   = w_dif[W] ^ w_dif[W-1];
         end
         FUN_DIV: begin
            w_fast_out = {a, {W{1'b1}}};
            w_fast_z   = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_acc_nxt = r_acc + (r_q[0] ? r_mcand : '0);
   assign w_prod    = r_neg_res ? -w_acc_nxt : w_acc_nxt;
   assign w_mul_ovf = !((&w_prod[OUT_WIDTH-1:W-1]) || (~|w_prod[OUT_WIDTH-1:W-1]));

   assign w_shift   = {r_rem, r_q[W-1]};
   assign w_diff    = w_shift - {1'b0, r_dvsr};
   assign w_ge      = ~w_diff[W];
   assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
   assign w_quo_nxt = {r_q[W-2:0], w_ge};
   assign w_quo_fix = r_neg_res ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = w_fast ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (r_cnt == '0) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div_ovf <= 1'b0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_q       <= '0;
         r_rem     <= '0;
         r_dvsr    <= '0;
         r_out     <= '0;
         r_carry   <= 1'b0;
         r_ovf     <= 1'b0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_cnt     <= CW'(W-1);
         r_is_div  <= alu_fun[0];
         r_neg_res <= a[W-1] ^ b[W-1];
         r_neg_rem <= a[W-1];
         r_div_ovf <= (a == {1'b1, {(W-1){1'b0}}}) && (&b);
         r_acc     <= '0;
         r_rem     <= '0;
         r_dvsr    <= w_b_mag;
         if (alu_fun[0]) begin
            r_mcand <= '0;
            r_q     <= w_a_mag;
         end else begin
            r_mcand <= {{W{1'b0}}, w_a_mag};
            r_q     <= w_b_mag;
         end
         if (w_fast) begin
            r_out   <= w_fast_out;
            r_carry <= w_fast_c;
            r_ovf   <= w_fast_v;
            r_dbz   <= w_fast_z;
         end
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_is_div) begin
            r_q   <= w_quo_nxt;
            r_rem <= w_rem_nxt;
         end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_q     <= r_q >> 1;
         end
         if (w_last) begin
            r_carry <= 1'b0;
            r_dbz   <= 1'b0;
            if (r_is_div) begin
               r_out <= {w_rem_fix, w_quo_fix};
               r_ovf <= r_div_ovf;
            end else begin
               r_out <= w_prod;
               r_ovf <= w_mul_ovf;
            end
         end
      end
   end

   assign arith_out   = r_out;
   assign carry_out   = r_carry;
   assign overflow    = r_ovf;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_seq_arith_unit;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [1:0]  alu_fun;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] arith_out;
   logic        carry_out;
   logic        overflow;
   logic        div_by_zero;

   int n_assert = 0;
   int n_fail   = 0;

   seq_arith_unit #(.DATA_WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_fun     (alu_fun),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .arith_out   (arith_out),
      .carry_out   (carry_out),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Reference: flags packed as {carry, overflow, div_by_zero}; lat counts cycles from accept.
   function automatic void model(input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic [1:0] tf, output logic [31:0] o,
                                 output logic [2:0] f, output int lat);
      longint sa, sb, ua, ub, r, q, rm;
      logic [63:0] t, tq, tr;
      sa = longint'($signed(ta));
      sb = longint'($signed(tb_v));
      ua = longint'(ta);
      ub = longint'(tb_v);
      o = '0; f = '0; lat = 17;
      case (tf)
         2'd0: begin
            r = sa + sb; t = r; o = t[31:0]; lat = 1;
            f[2] = (ua + ub) > 65535;
            f[1] = (r > 32767) || (r < -32768);
         end
         2'd1: begin
            r = sa - sb; t = r; o = t[31:0]; lat = 1;
            f[2] = ua < ub;
            f[1] = (r > 32767) || (r < -32768);
         end
         2'd2: begin
            r = sa * sb; t = r; o = t[31:0];
            f[1] = (r > 32767) || (r < -32768);
         end
         default: begin
            if (sb == 0) begin
               o = {ta, 16'hFFFF}; f[0] = 1'b1; lat = 1;
            end else if (sa == -32768 && sb == -1) begin
               o = 32'h0000_8000; f[1] = 1'b1;
            end else begin
               q = sa / sb; rm = sa % sb; tq = q; tr = rm;
               o = {tr[15:0], tq[15:0]};
            end
         end
      endcase
   endfunction

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tf,
                         input int stall, input string tag);
      logic [31:0] e_out;
      logic [2:0]  e_f;
      int          e_lat, lat, n;
      logic        busy_ok;
      model(ta, tb_v, tf, e_out, e_f, e_lat);
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      a = ta; b = tb_v; alu_fun = tf; in_valid = 1'b1; out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); alu_fun = 2'($urandom);
      lat = 1; busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1; lat++;
      end
      chk({tag, ".latency"}, lat, e_lat);
      chk({tag, ".busy"}, {in_ready, busy_ok}, 2'b01);
      chk({tag, ".out"}, arith_out, e_out);
      chk({tag, ".flags"}, {carry_out, overflow, div_by_zero}, e_f);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); alu_fun = 2'($urandom);
         @(posedge clk); #1;
         chk({tag, ".stall"}, {out_valid, in_ready, arith_out, carry_out, overflow, div_by_zero},
             {1'b1, 1'b0, e_out, e_f});
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".handshake"}, {out_valid, in_ready, arith_out, carry_out, overflow, div_by_zero},
          {1'b0, 1'b1, e_out, e_f});
      @(posedge clk); #1;
      chk({tag, ".no_queue"}, out_valid, 1'b0);
   endtask

   initial begin
      logic seen;
      logic [15:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_fun = '0; out_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("reset_state", {in_ready, out_valid, arith_out, carry_out, overflow, div_by_zero},
          {1'b1, 1'b0, 32'h0, 3'b000});
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_op(16'h7FFF, 16'h0001, 2'd0, 0, "add_ovf");
      chk("add_ovf.const", {arith_out, carry_out, overflow}, {32'h0000_8000, 1'b0, 1'b1});
      run_op(16'h0003, 16'h0005, 2'd1, 0, "sub_borrow");
      chk("sub_borrow.const", {arith_out, carry_out, overflow}, {32'hFFFF_FFFE, 1'b1, 1'b0});
      run_op(16'hFFFF, 16'h0001, 2'd0, 0, "add_carry");
      run_op(-16'sd300, 16'd200, 2'd2, 0, "mul_neg");
      chk("mul_neg.const", {arith_out, overflow}, {32'hFFFF_15A0, 1'b1});
      run_op(16'h8000, 16'h8000, 2'd2, 1, "mul_minmin");
      run_op(-16'sd7, 16'd2, 2'd3, 0, "div_neg");
      chk("div_neg.const", arith_out, 32'hFFFF_FFFD);
      run_op(16'h8000, 16'hFFFF, 2'd3, 0, "div_ovf");
      chk("div_ovf.const", {arith_out, overflow}, {32'h0000_8000, 1'b1});
      run_op(16'h1234, 16'h0000, 2'd3, 0, "div_zero");
      chk("div_zero.const", {arith_out, div_by_zero, overflow}, {32'h1234_FFFF, 1'b1, 1'b0});
      run_op(16'd100, -16'sd7, 2'd3, 0, "div_negdiv");
      run_op(16'h8000, 16'h8000, 2'd3, 0, "div_minmin");
      run_op(16'h0042, 16'h0017, 2'd0, 5, "stall5");

      // Abort a multiply with reset eight cycles in.
      a = 16'd1234; b = 16'd567; alu_fun = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("rst_abort.outputs", {in_ready, out_valid, arith_out, carry_out, overflow, div_by_zero},
          {1'b1, 1'b0, 32'h0, 3'b000});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("rst_abort.no_valid", {seen, in_ready}, 2'b01);

      for (int i = 0; i < 60; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 16'h0000;
            1: ra = 16'h8000;
            2: rb = 16'hFFFF;
            3: rb = 16'($urandom_range(1, 9));
            default: ;
         endcase
         run_op(ra, rb, 2'($urandom_range(0, 3)), $urandom_range(0, 2), $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
